// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file write controller.
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_wr_ctrl.sv
// Register-file write port arbiter: clears all registers after reset, then
// merges core writeback and debug writes with writeback priority and a starve override.
module regfile_wr_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  wb_ready,
  input  logic                  dbg_valid,
  input  logic [REG_ADDR_W-1:0] dbg_rd,
  input  logic [XLEN-1:0]       dbg_data,
  output logic                  dbg_ready,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       WD3,
  output logic                  init_done,
  output logic [15:0]           wb_stall_cnt
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);
  localparam logic [3:0]            LIM      = 4'(STARVE_LIM);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [REG_ADDR_W-1:0]   r_clr_idx;
  logic [3:0]              r_dbg_wait;
  logic [15:0]             r_wb_stall_cnt;

  logic                    w_starve;
  logic                    w_wb_ready;
  logic                    w_dbg_ready;
  logic                    w_wb_acc;
  logic                    w_dbg_acc;
  logic [REG_ADDR_W-1:0]   w_acc_rd;
  logic [XLEN-1:0]         w_acc_data;

  assign w_starve = (r_dbg_wait == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ready signals depend only on state, wb_valid and the starve counter, never on data.
  always_comb begin
    w_state_next = r_state;
    w_wb_ready   = 1'b0;
    w_dbg_ready  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_idx == LAST_IDX) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_starve) begin
          w_dbg_ready = 1'b1;
        end else begin
          w_wb_ready  = 1'b1;
          w_dbg_ready = ~wb_valid;
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
      end
    endcase
  end

  assign w_wb_acc   = wb_valid & w_wb_ready;
  assign w_dbg_acc  = dbg_valid & w_dbg_ready;
  assign w_acc_rd   = w_wb_acc ? wb_rd : dbg_rd;
  assign w_acc_data = w_wb_acc ? wb_data : dbg_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_idx <= '0;
      RegWrite  <= 1'b0;
      rd        <= '0;
      WD3       <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_idx <= r_clr_idx + 1'b1;
      RegWrite  <= 1'b1;
      rd        <= r_clr_idx;
      WD3       <= '0;
    end else if (w_wb_acc || w_dbg_acc) begin
      // A write to x0 is consumed but never reaches the register file.
      RegWrite  <= (w_acc_rd != '0);
      rd        <= w_acc_rd;
      WD3       <= w_acc_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbg_wait <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_dbg_acc) begin
        r_dbg_wait <= '0;
      end else if (dbg_valid && !w_dbg_ready && (r_dbg_wait < LIM)) begin
        r_dbg_wait <= r_dbg_wait + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && wb_valid && !w_wb_ready &&
                 (r_wb_stall_cnt != 16'hFFFF)) begin
      r_wb_stall_cnt <= r_wb_stall_cnt + 16'd1;
    end
  end

  assign wb_ready     = w_wb_ready;
  assign dbg_ready    = w_dbg_ready;
  assign init_done    = (r_state == ST_RUN);
  assign wb_stall_cnt = r_wb_stall_cnt;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Scoreboard bench for regfile_wr_ctrl: stimulus pushes expected writes, a negedge monitor checks them.
module tb_regfile_wr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        dbg_valid;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WD3;
  logic        init_done;
  logic [15:0] wb_stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  regfile_wr_ctrl #(.STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .RegWrite(RegWrite), .rd(rd), .WD3(WD3),
    .init_done(init_done), .wb_stall_cnt(wb_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (RegWrite === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got rd=%0d WD3=%0h expected no write", rd, WD3);
      end else begin
        e = exp_q.pop_front();
        if ({rd, WD3} !== e) begin
          n_err++;
          $display("FAIL wr: got rd=%0d WD3=%0h expected rd=%0d WD3=%0h",
                   rd, WD3, e[36:32], e[31:0]);
        end else begin
          $display("ok   wr: rd=%0d WD3=%0h", rd, WD3);
        end
      end
    end
  end

  // Called at a negedge with rst_n low; releases reset and walks the clear sequence.
  task automatic do_clear();
    for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), 32'h0});
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      if (e == 1)  chk("clr_wb_ready", {31'b0, wb_ready}, 32'd0);
      if (e == 1)  chk("clr_dbg_ready", {31'b0, dbg_ready}, 32'd0);
      if (e == 31) chk("init_done_pre", {31'b0, init_done}, 32'd0);
      if (e == 32) chk("init_done_post", {31'b0, init_done}, 32'd1);
    end
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = r; wb_data = d;
    @(negedge clk);
    chk("wb_ready", {31'b0, wb_ready}, 32'd1);
    if (r != 5'd0) exp_q.push_back({r, d});
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic dbg_write(input logic [4:0] r, input logic [31:0] d);
    dbg_valid = 1'b1; dbg_rd = r; dbg_data = d;
    @(negedge clk);
    chk("dbg_ready", {31'b0, dbg_ready}, 32'd1);
    if (r != 5'd0) exp_q.push_back({r, d});
    @(posedge clk); #1;
    dbg_valid = 1'b0;
  endtask

  // Both requesters active: expect wb x4, dbg on cycle 5, wb again on cycle 6.
  task automatic starve_run(input logic [4:0] base);
    logic exp_dbg;
    wb_valid = 1'b1; wb_rd = base; wb_data = 32'h100 + 32'(base);
    dbg_valid = 1'b1; dbg_rd = 5'd10; dbg_data = 32'hD0D0_0000 | 32'(base);
    for (int c = 0; c < 6; c++) begin
      exp_dbg = (c == 4);
      @(negedge clk);
      chk("starve_wb_ready", {31'b0, wb_ready}, {31'b0, ~exp_dbg});
      chk("starve_dbg_ready", {31'b0, dbg_ready}, {31'b0, exp_dbg});
      if (exp_dbg) exp_q.push_back({dbg_rd, dbg_data});
      else         exp_q.push_back({wb_rd, wb_data});
      @(posedge clk); #1;
      if (exp_dbg) dbg_valid = 1'b0;
      else begin
        wb_rd   = wb_rd + 5'd1;
        wb_data = wb_data + 32'd1;
      end
    end
    wb_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    dbg_valid = 1'b0; dbg_rd = '0; dbg_data = '0;
    #2;
    chk("rst_RegWrite", {31'b0, RegWrite}, 32'd0);
    chk("rst_rd", {27'b0, rd}, 32'd0);
    chk("rst_WD3", WD3, 32'd0);
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    chk("rst_stall", {16'b0, wb_stall_cnt}, 32'd0);
    @(negedge clk);
    do_clear();
    @(posedge clk); #1;

    wb_write(5'd5, 32'hDEADBEEF);
    repeat (2) @(posedge clk); #1;

    chk("stall_before", {16'b0, wb_stall_cnt}, 32'd0);
    starve_run(5'd1);
    @(negedge clk);
    chk("stall_after_starve", {16'b0, wb_stall_cnt}, 32'd1);
    @(posedge clk); #1;

    dbg_write(5'd0, 32'h1234);
    repeat (2) @(posedge clk); #1;
    dbg_write(5'd7, 32'h0000_7777);
    repeat (2) @(posedge clk); #1;

    @(negedge clk);
    force dut.r_wb_stall_cnt = 16'hFFFE;
    #1 release dut.r_wb_stall_cnt;
    #1 chk("stall_preload", {16'b0, wb_stall_cnt}, 32'h0000FFFE);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      starve_run(5'(11 + 6 * i));
      @(negedge clk);
      chk("stall_sat", {16'b0, wb_stall_cnt}, 32'h0000FFFF);
      @(posedge clk); #1;
    end

    // Write accepted and on the outputs, then reset before it is seen at negedge.
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    chk("pend_RegWrite", {31'b0, RegWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_RegWrite", {31'b0, RegWrite}, 32'd0);
    chk("rst2_rd", {27'b0, rd}, 32'd0);
    chk("rst2_WD3", WD3, 32'd0);
    chk("rst2_init_done", {31'b0, init_done}, 32'd0);
    chk("rst2_wb_ready", {31'b0, wb_ready}, 32'd0);
    chk("rst2_stall", {16'b0, wb_stall_cnt}, 32'd0);
    @(negedge clk);
    do_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wr_ctrl.md
REGFILE_WR_CTRL -- requirements
Module: regfile_wr_ctrl

Interface
REQ-001 Parameter STARVE_LIM, 4, debug wait cycles before debug overrides writeback priority (range 1..15).
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port wb_valid  input  1  core writeback request.
REQ-005 Port wb_rd  input  5  writeback destination register.
REQ-006 Port wb_data  input  32  writeback data.
REQ-007 Port wb_ready  output  1  writeback request accepted this cycle.
REQ-008 Port dbg_valid  input  1  debug/loader write request.
REQ-009 Port dbg_rd  input  5  debug destination register.
REQ-010 Port dbg_data  input  32  debug data.
REQ-011 Port dbg_ready  output  1  debug request accepted this cycle.
REQ-012 Port RegWrite  output  1  register-file write enable, registered.
REQ-013 Port rd  output  5  register-file write address, registered.
REQ-014 Port WD3  output  32  register-file write data, registered.
REQ-015 Port init_done  output  1  high once the clear sequence has completed.
REQ-016 Port wb_stall_cnt  output  16  count of RUN cycles with wb_valid=1 and wb_ready=0, saturating.

Function
REQ-017 FSM states are CLEAR and RUN; reset enters CLEAR with clear index 0.
REQ-018 In CLEAR, wb_ready and dbg_ready are 0; rising edge k (k=1..32) after reset release loads RegWrite=1, rd=k-1, WD3=0.
REQ-019 The FSM moves CLEAR->RUN on the edge that loads rd=31; init_done is 1 in every cycle the FSM is in RUN; RUN has no exit except reset.
REQ-020 Handshake: a request is accepted on a rising edge where valid and ready are both 1; requesters hold valid, rd and data stable until accepted; ready never depends on data.
REQ-021 At most one request is accepted per cycle; wb_ready and dbg_ready are never both 1.
REQ-022 In RUN, writeback has priority: wb_ready=1 and dbg_ready=(~wb_valid), unless starve applies.
REQ-023 A counter dbg_wait increments each RUN cycle with dbg_valid=1 and dbg_ready=0, saturates at STARVE_LIM and clears on debug acceptance.
REQ-024 When dbg_wait==STARVE_LIM, dbg_ready=1 and wb_ready=0 for that cycle (starve override).
REQ-025 Latency is one cycle: a request accepted at edge N drives RegWrite/rd/WD3 from edge N until edge N+1, so it is written at edge N+1.
REQ-026 An accepted request with rd=0 is consumed, but RegWrite is 0 in the following cycle (x0 remains zero).
REQ-027 In RUN cycles where nothing is accepted, RegWrite is 0 and rd/WD3 hold their previous values.
REQ-028 wb_stall_cnt increments by 1 per qualifying cycle, saturates at 16'hFFFF and never wraps.

Reset
REQ-029 Asserting rst_n low at any time immediately forces: state CLEAR, clear index 0, dbg_wait 0, wb_stall_cnt 0, RegWrite 0, rd 0, WD3 0, init_done 0, wb_ready 0, dbg_ready 0.
REQ-030 A reset during CLEAR or RUN discards any in-flight write and restarts the full 32-register clear after release.

Structure
REQ-031 Shared package regfile_pkg holds XLEN=32, NUM_REGS=32, REG_ADDR_W=5 and the CLEAR/RUN state enum.
REQ-032 The block is a single module with no sub-module; the arbitration, clear counter and output register are inline.

Verification
REQ-033 Reset release with no requests -> edges 1..32 show RegWrite=1 with rd=0..31 and WD3=0, then RegWrite=0; init_done=1 from edge 32 onward.
REQ-034 In RUN, wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF for one cycle -> next cycle shows RegWrite=1, rd=5, WD3=0xDEADBEEF, followed by RegWrite=0.
REQ-035 wb_valid and dbg_valid both held at 1 with STARVE_LIM=4 -> wb accepted 4 consecutive cycles, dbg accepted on the 5th, then wb resumes; wb_stall_cnt=1.
REQ-036 dbg_valid=1, dbg_rd=0, dbg_data=0x1234 -> dbg_ready=1 and the request is consumed; the next cycle has RegWrite=0.
REQ-037 rst_n pulsed low during RUN while a write is pending on the outputs -> outputs are 0 immediately, init_done=0, and the 32-cycle clear repeats from rd=0.
REQ-038 wb_stall_cnt preloaded by forcing 16'hFFFE, then 3 stalled wb cycles -> wb_stall_cnt reads 16'hFFFF.
